// File: rtl/dbg_trace_packetizer.sv
// Debug trace packetizer: queues wide trace words and serializes each one into
// a header + payload flit packet on the Debug NoC, with stall or drop-and-count overflow.
module dbg_trace_packetizer #(
  parameter int unsigned TRACE_WIDTH     = 80,
  parameter int unsigned FLIT_DATA_WIDTH = 16,
  parameter int unsigned FLIT_TYPE_WIDTH = 2,
  parameter int unsigned VCHANNELS       = 1,
  parameter int unsigned TRACE_VCHANNEL  = 0,
  parameter int unsigned CONF_VCHANNEL   = 0,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned STALL_MODE      = 1,
  parameter logic [4:0]  DEST            = 5'd0,
  parameter logic [2:0]  CLASS           = 3'h4,
  parameter logic [2:0]  OVF_CLASS       = 3'h5,
  parameter logic [7:0]  CORE_ID         = 8'd0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [TRACE_WIDTH-1:0]                   trace_in,
  input  logic                                     trace_in_valid,
  output logic                                     trace_in_ready,
  output logic [FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH-1:0] dbgnoc_out_flit,
  output logic [VCHANNELS-1:0]                     dbgnoc_out_valid,
  input  logic [VCHANNELS-1:0]                     dbgnoc_out_ready,
  input  logic                                     conf_out_rts,
  output logic                                     conf_out_cts,
  input  logic                                     conf_out_valid,
  input  logic [FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH-1:0] conf_out_flit,
  output logic                                     sys_clk_disable,
  output logic [15:0]                              drop_count
);

  localparam int unsigned N     = (TRACE_WIDTH + FLIT_DATA_WIDTH - 1) / FLIT_DATA_WIDTH;
  localparam int unsigned EXT_W = N * FLIT_DATA_WIDTH;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_HDR  = FLIT_TYPE_WIDTH'(2'b01);
  localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_PAY  = FLIT_TYPE_WIDTH'(2'b00);
  localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_LAST = FLIT_TYPE_WIDTH'(2'b10);

  typedef enum logic [2:0] {IDLE, CONF, HDR, PAY, OVF_HDR, OVF_CNT} state_t;

  state_t                 state, state_next;
  logic [TRACE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, drop, fire, trace_busy, last_pay, ovf_start;
  logic [EXT_W-1:0]       word_buf;
  logic [IDX_W-1:0]       idx;
  logic [15:0]            ovf_cnt;

  assign fifo_full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty     = (fifo_cnt == '0);
  assign trace_in_ready = (STALL_MODE != 0) ? ~fifo_full : 1'b1;
  // A full FIFO still accepts a word when the packet engine pops in the same cycle.
  assign push           = trace_in_valid & trace_in_ready & (~fifo_full | pop);
  assign drop           = trace_in_valid & trace_in_ready & fifo_full & ~pop;
  assign trace_busy     = (state == HDR) || (state == PAY) || (state == OVF_HDR) || (state == OVF_CNT);
  assign fire           = trace_busy & dbgnoc_out_ready[TRACE_VCHANNEL];
  assign last_pay       = (idx == IDX_W'(N - 1));

  // Next-state, FIFO pop and NoC/config port outputs.
  always_comb begin
    state_next       = state;
    pop              = 1'b0;
    ovf_start        = 1'b0;
    conf_out_cts     = 1'b0;
    dbgnoc_out_valid = '0;
    dbgnoc_out_flit  = '0;
    case (state)
      IDLE: begin
        if (conf_out_rts) begin
          state_next = CONF;
        end else if (drop_count != 16'd0) begin
          state_next = OVF_HDR;
          ovf_start  = 1'b1;
        end else if (!fifo_empty) begin
          state_next = HDR;
          pop        = 1'b1;
        end
      end
      CONF: begin
        conf_out_cts                    = conf_out_rts | conf_out_valid;
        dbgnoc_out_valid[CONF_VCHANNEL] = conf_out_valid & conf_out_cts;
        dbgnoc_out_flit                 = conf_out_flit;
        if (!(conf_out_rts | conf_out_valid)) state_next = IDLE;
      end
      HDR: begin
        dbgnoc_out_valid[TRACE_VCHANNEL] = 1'b1;
        dbgnoc_out_flit = {TYPE_HDR, FLIT_DATA_WIDTH'({DEST, CLASS, CORE_ID})};
        if (fire) state_next = PAY;
      end
      PAY: begin
        dbgnoc_out_valid[TRACE_VCHANNEL] = 1'b1;
        dbgnoc_out_flit = {last_pay ? TYPE_LAST : TYPE_PAY, word_buf[EXT_W-1 -: FLIT_DATA_WIDTH]};
        if (fire && last_pay) state_next = IDLE;
      end
      OVF_HDR: begin
        dbgnoc_out_valid[TRACE_VCHANNEL] = 1'b1;
        dbgnoc_out_flit = {TYPE_HDR, FLIT_DATA_WIDTH'({DEST, OVF_CLASS, CORE_ID})};
        if (fire) state_next = OVF_CNT;
      end
      OVF_CNT: begin
        dbgnoc_out_valid[TRACE_VCHANNEL] = 1'b1;
        dbgnoc_out_flit = {TYPE_LAST, FLIT_DATA_WIDTH'(ovf_cnt)};
        if (fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= trace_in;
  end

  // FIFO bookkeeping, packet buffer, payload index and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      word_buf        <= '0;
      idx             <= '0;
      ovf_cnt         <= '0;
      drop_count      <= '0;
      sys_clk_disable <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);

      if (pop) begin
        word_buf <= EXT_W'(fifo_mem[rd_ptr]);
        idx      <= '0;
      end else if (state == PAY && fire) begin
        word_buf <= word_buf << FLIT_DATA_WIDTH;
        idx      <= idx + 1'b1;
      end

      if (ovf_start) begin
        ovf_cnt    <= drop_count;
        drop_count <= drop ? 16'd1 : 16'd0;
      end else if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end

      sys_clk_disable <= (STALL_MODE != 0) && fifo_full;
    end
  end

endmodule

// File: tb/tb_dbg_trace_packetizer.sv
// Bench for dbg_trace_packetizer: a stall-mode 80-bit instance under random and
// directed traffic, and a drop-mode 40-bit instance for overflow packets.
module tb_dbg_trace_packetizer;

  logic clk;
  logic rst;

  logic [79:0] a_in;
  logic        a_in_valid, a_in_ready;
  logic [17:0] a_flit;
  logic [0:0]  a_valid, a_out_ready;
  logic        a_rts, a_cts, a_conf_valid;
  logic [17:0] a_conf_flit;
  logic        a_clk_dis;
  logic [15:0] a_drop;

  logic [39:0] b_in;
  logic        b_in_valid, b_in_ready;
  logic [17:0] b_flit;
  logic [0:0]  b_valid, b_out_ready;
  logic        b_rts, b_cts, b_conf_valid;
  logic [17:0] b_conf_flit;
  logic        b_clk_dis;
  logic [15:0] b_drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_a[$];
  logic [17:0] exp_b[$];
  int          a_acc, a_hdr_fires;
  bit          a_prev_full, a_prev_hold, a_prev_last, a_auto;
  logic [17:0] a_prev_flit;
  bit          b_prev_hold, b_prev_last;
  logic [17:0] b_prev_flit;

  dbg_trace_packetizer u_dut_a (
    .clk(clk), .rst(rst),
    .trace_in(a_in), .trace_in_valid(a_in_valid), .trace_in_ready(a_in_ready),
    .dbgnoc_out_flit(a_flit), .dbgnoc_out_valid(a_valid), .dbgnoc_out_ready(a_out_ready),
    .conf_out_rts(a_rts), .conf_out_cts(a_cts), .conf_out_valid(a_conf_valid),
    .conf_out_flit(a_conf_flit), .sys_clk_disable(a_clk_dis), .drop_count(a_drop)
  );

  dbg_trace_packetizer #(.TRACE_WIDTH(40), .STALL_MODE(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .trace_in(b_in), .trace_in_valid(b_in_valid), .trace_in_ready(b_in_ready),
    .dbgnoc_out_flit(b_flit), .dbgnoc_out_valid(b_valid), .dbgnoc_out_ready(b_out_ready),
    .conf_out_rts(b_rts), .conf_out_cts(b_cts), .conf_out_valid(b_conf_valid),
    .conf_out_flit(b_conf_flit), .sys_clk_disable(b_clk_dis), .drop_count(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] rand80();
    return 80'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Reference packet: header, then the word cut into 16-bit slices MSB first.
  function automatic void push_pkt_a(input logic [79:0] w);
    exp_a.push_back({2'b01, 5'd0, 3'h4, 8'h00});
    for (int k = 0; k < 5; k++)
      exp_a.push_back({(k == 4) ? 2'b10 : 2'b00, 16'(w >> (16 * (4 - k)))});
  endfunction

  function automatic void push_pkt_b(input logic [39:0] w);
    logic [47:0] ext;
    ext = {8'h00, w};
    exp_b.push_back({2'b01, 5'd0, 3'h4, 8'h00});
    for (int k = 0; k < 3; k++)
      exp_b.push_back({(k == 2) ? 2'b10 : 2'b00, 16'(ext >> (16 * (2 - k)))});
  endfunction

  function automatic void model_reset();
    exp_a.delete();
    exp_b.delete();
    a_acc       = 0;
    a_hdr_fires = 0;
    a_prev_full = 1'b0;
    a_prev_hold = 1'b0;
    a_prev_last = 1'b0;
    b_prev_hold = 1'b0;
    b_prev_last = 1'b0;
  endfunction

  // Stall-mode instance: occupancy = words accepted minus packets started.
  task automatic score_a();
    bit cur_hdr, fire, is_last;
    int occ;
    if (rst) return;
    cur_hdr = a_valid[0] && !a_cts && (a_flit[17:16] == 2'b01);
    occ     = a_acc - a_hdr_fires - int'(cur_hdr);
    check("a_in_ready", 80'(a_in_ready), 80'(occ < 4));
    check("a_clk_dis", 80'(a_clk_dis), 80'(a_prev_full));
    check("a_drop_zero", 80'(a_drop), 80'(0));
    if (a_cts) begin
      check("a_conf_flit", 80'(a_flit), 80'(a_conf_flit));
      check("a_conf_vld", 80'(a_valid), 80'(a_conf_valid));
    end
    if (a_prev_hold) begin
      check("a_hold_vld", 80'(a_valid), 80'(1));
      check("a_hold_flit", 80'(a_flit), 80'(a_prev_flit));
    end
    if (a_prev_last) check("a_gap", 80'(a_valid), 80'(0));
    fire    = a_valid[0] && !a_cts && a_out_ready[0];
    is_last = fire && (a_flit[17:16] == 2'b10);
    if (fire) begin
      check("a_q", 80'(exp_a.size() != 0), 80'(1));
      if (exp_a.size() != 0) check("a_flit", 80'(a_flit), 80'(exp_a.pop_front()));
      if (cur_hdr) a_hdr_fires++;
    end
    a_prev_hold = a_valid[0] && !a_cts && !a_out_ready[0];
    a_prev_last = is_last;
    a_prev_flit = a_flit;
    a_prev_full = (occ == 4);
    if (a_in_valid && occ < 4) begin
      a_acc++;
      if (a_auto) push_pkt_a(a_in);
    end
  endtask

  task automatic score_b();
    bit fire;
    if (rst) return;
    check("b_in_ready", 80'(b_in_ready), 80'(1));
    check("b_clk_dis", 80'(b_clk_dis), 80'(0));
    if (b_prev_hold) begin
      check("b_hold_vld", 80'(b_valid), 80'(1));
      check("b_hold_flit", 80'(b_flit), 80'(b_prev_flit));
    end
    if (b_prev_last) check("b_gap", 80'(b_valid), 80'(0));
    fire = b_valid[0] && !b_cts && b_out_ready[0];
    if (fire) begin
      check("b_q", 80'(exp_b.size() != 0), 80'(1));
      if (exp_b.size() != 0) check("b_flit", 80'(b_flit), 80'(exp_b.pop_front()));
    end
    b_prev_hold = b_valid[0] && !b_cts && !b_out_ready[0];
    b_prev_last = fire && (b_flit[17:16] == 2'b10);
    b_prev_flit = b_flit;
  endtask

  task automatic cycle();
    #1;
    score_a();
    score_b();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    #1;
    check("rst_a_valid", 80'(a_valid), 80'(0));
    check("rst_a_cts", 80'(a_cts), 80'(0));
    check("rst_a_clk_dis", 80'(a_clk_dis), 80'(0));
    check("rst_a_ready", 80'(a_in_ready), 80'(1));
    check("rst_a_drop", 80'(a_drop), 80'(0));
    check("rst_b_valid", 80'(b_valid), 80'(0));
    check("rst_b_drop", 80'(b_drop), 80'(0));
    check("rst_b_cts", 80'(b_cts), 80'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain_a(input int budget, input bit rnd);
    for (int i = 0; i < budget && exp_a.size() != 0; i++) begin
      a_out_ready = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
    end
    check("a_drain", 80'(exp_a.size()), 80'(0));
  endtask

  task automatic drain_b(input int budget);
    for (int i = 0; i < budget && exp_b.size() != 0; i++) begin
      b_out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    check("b_drain", 80'(exp_b.size()), 80'(0));
  endtask

  initial begin
    logic [17:0] held;
    logic [39:0] b_words [7];
    int          acc0;

    rst = 1'b1;
    a_in = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_rts = 1'b0; a_conf_valid = 1'b0; a_conf_flit = '0;
    b_in = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_rts = 1'b0; b_conf_valid = 1'b0; b_conf_flit = '0;
    a_auto = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Known 80-bit word with the sink always ready.
    a_auto = 1'b0;
    a_out_ready = 1'b1;
    exp_a.push_back(18'h10400);
    exp_a.push_back(18'h01111);
    exp_a.push_back(18'h02222);
    exp_a.push_back(18'h03333);
    exp_a.push_back(18'h04444);
    exp_a.push_back(18'h25555);
    a_in = 80'h1111_2222_3333_4444_5555;
    a_in_valid = 1'b1;
    cycle();
    a_in_valid = 1'b0;
    drain_a(30, 1'b0);

    // Random words with random sink backpressure.
    a_auto = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in        = rand80();
      a_out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    a_in_valid = 1'b0;
    drain_a(300, 1'b1);

    // Mid-payload backpressure, then a config request arriving during the packet.
    a_out_ready = 1'b0;
    a_in = rand80();
    a_in_valid = 1'b1;
    cycle();
    a_in_valid = 1'b0;
    for (int i = 0; i < 5 && !a_valid[0]; i++) cycle();
    check("a_pkt_start", 80'(a_valid), 80'(1));
    a_out_ready = 1'b1;
    cycle();
    cycle();
    a_out_ready = 1'b0;
    a_rts = 1'b1;
    held = a_flit;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("a_cts_mid_pkt", 80'(a_cts), 80'(0));
    end
    check("a_hold3", 80'(a_flit), 80'(held));
    a_out_ready = 1'b1;
    for (int i = 0; i < 20 && !a_cts; i++) cycle();
    check("a_cts_up", 80'(a_cts), 80'(1));
    check("a_cts_after_last", 80'(exp_a.size()), 80'(0));
    a_conf_valid = 1'b1;
    a_conf_flit  = 18'($urandom());
    cycle();
    check("a_conf_pass", 80'(a_flit), 80'(a_conf_flit));
    check("a_conf_pass_vld", 80'(a_valid), 80'(1));
    a_conf_valid = 1'b0;
    a_rts = 1'b0;
    cycle();
    check("a_cts_release", 80'(a_cts), 80'(0));
    cycle();

    // Fill the FIFO against a blocked sink to force a system stall.
    acc0 = a_acc;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in = rand80();
      cycle();
    end
    a_in_valid = 1'b0;
    cycle();
    check("a_full_ready", 80'(a_in_ready), 80'(0));
    check("a_full_stall", 80'(a_clk_dis), 80'(1));
    check("a_full_count", 80'(a_acc - acc0), 80'(5));
    drain_a(200, 1'b1);
    check("a_stall_release", 80'(a_clk_dis), 80'(0));

    // Reset while a packet is stalled with more words queued behind it.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in = rand80();
    cycle();
    a_in = rand80();
    cycle();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("a_pre_rst_vld", 80'(a_valid), 80'(1));
    apply_reset();
    a_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    check("a_post_rst_idle", 80'(a_valid), 80'(0));

    // Drop mode, 40-bit words: hold config so nothing drains while 7 words arrive.
    b_rts = 1'b1;
    b_out_ready = 1'b0;
    cycle();
    b_in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      b_words[k] = (k == 0) ? 40'hAB_CDEF_0123 : 40'({$urandom(), $urandom()});
      b_in = b_words[k];
      cycle();
    end
    b_in_valid = 1'b0;
    cycle();
    check("b_drop_cnt", 80'(b_drop), 80'(3));
    check("b_cts_conf", 80'(b_cts), 80'(1));
    check("b_idle_vld", 80'(b_valid), 80'(0));
    exp_b.push_back(18'h10500);
    exp_b.push_back(18'h20003);
    exp_b.push_back(18'h10400);
    exp_b.push_back(18'h000AB);
    exp_b.push_back(18'h0CDEF);
    exp_b.push_back(18'h20123);
    for (int k = 1; k < 4; k++) push_pkt_b(b_words[k]);
    b_rts = 1'b0;
    drain_b(300);
    check("b_drop_cleared", 80'(b_drop), 80'(0));
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
